// File: rtl/serial_min3_ctrl.sv
// rtl/serial_min3_ctrl.sv - bit-serial minimum-of-three sequencer with winner tracking
//
// Accepts three WIDTH-bit operands on a valid/ready handshake and streams
// min(a,b,c) MSB-first, one bit per clock. Candidates are eliminated bit by
// bit; no operand is ever compared as a whole word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the operation in progress
//   in_valid   operands a/b/c are valid
//   in_ready   operands can be accepted (IDLE only)
//   a, b, c    operands 0, 1, 2
//   bit_valid  min_bit carries a result bit this cycle
//   min_bit    current result bit, MSB first
//   bit_last   current bit is the LSB (result done)
//   min_idx    winning operand index, valid with bit_last
//   busy       streaming in progress

module serial_min3_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             bit_valid,
    output logic             min_bit,
    output logic             bit_last,
    output logic [1:0]       min_idx,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;

    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  sc_q, sc_d;
    // alive[2] tracks a, alive[1] tracks b, alive[0] tracks c
    logic [2:0]        alive_q, alive_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bit_valid_q, bit_valid_d;
    logic              min_bit_q, min_bit_d;
    logic              bit_last_q, bit_last_d;
    logic [1:0]        min_idx_q, min_idx_d;

    logic              accept;
    logic              cnt_zero;
    logic [2:0]        msb_bits;
    logic              any_alive_zero;
    logic              m_bit;
    logic [2:0]        alive_upd;
    logic [1:0]        idx_upd;

    assign accept   = in_valid && (state_q == S_IDLE);
    assign cnt_zero = (cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_zero) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_SHIFT: busy     = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit-serial elimination
    // ------------------------------------------------------------------
    always_comb begin
        msb_bits       = {sa_q[WIDTH-1], sb_q[WIDTH-1], sc_q[WIDTH-1]};
        // A surviving candidate with a 0 here forces the minimum's bit to 0
        any_alive_zero = |(alive_q & ~msb_bits);
        m_bit          = ~any_alive_zero;
        // When m is 0, candidates showing a 1 are strictly larger and drop out.
        // When m is 1, every survivor shows 1, so nobody is eliminated.
        alive_upd      = m_bit ? alive_q : (alive_q & ~msb_bits);

        // Lowest index wins ties: a, then b, then c
        if (alive_upd[2]) begin
            idx_upd = 2'd0;
        end else if (alive_upd[1]) begin
            idx_upd = 2'd1;
        end else begin
            idx_upd = 2'd2;
        end
    end

    always_comb begin
        sa_d        = sa_q;
        sb_d        = sb_q;
        sc_d        = sc_q;
        alive_d     = alive_q;
        cnt_d       = cnt_q;
        bit_valid_d = 1'b0;
        min_bit_d   = 1'b0;
        bit_last_d  = 1'b0;
        min_idx_d   = min_idx_q;

        if (flush) begin
            alive_d   = '0;
            cnt_d     = '0;
            min_idx_d = '0;
        end else if (state_q == S_SHIFT) begin
            bit_valid_d = 1'b1;
            min_bit_d   = m_bit;
            bit_last_d  = cnt_zero;
            alive_d     = alive_upd;
            sa_d        = {sa_q[WIDTH-2:0], 1'b0};
            sb_d        = {sb_q[WIDTH-2:0], 1'b0};
            sc_d        = {sc_q[WIDTH-2:0], 1'b0};
            cnt_d       = cnt_q - CW'(1);
            if (cnt_zero) begin
                min_idx_d = idx_upd;
            end
        end else if (accept) begin
            sa_d    = a;
            sb_d    = b;
            sc_d    = c;
            alive_d = 3'b111;
            cnt_d   = CNT_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q        <= '0;
            sb_q        <= '0;
            sc_q        <= '0;
            alive_q     <= '0;
            cnt_q       <= '0;
            bit_valid_q <= 1'b0;
            min_bit_q   <= 1'b0;
            bit_last_q  <= 1'b0;
            min_idx_q   <= '0;
        end else begin
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sc_q        <= sc_d;
            alive_q     <= alive_d;
            cnt_q       <= cnt_d;
            bit_valid_q <= bit_valid_d;
            min_bit_q   <= min_bit_d;
            bit_last_q  <= bit_last_d;
            min_idx_q   <= min_idx_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign min_bit   = min_bit_q;
    assign bit_last  = bit_last_q;
    assign min_idx   = min_idx_q;

endmodule
